pipeline_stall_controller: RTL and testbench
============================================

// Module: pipeline_stall_controller
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline.
//  - Merges the hazard-detection stall request, ID-stage branch/jump redirect, instruction-fetch wait and data-memory wait.
//  - Produces one consistent set of per-stage write/flush/bubble enables, plus the PC write enable.
//  - Owns the post-reset pipeline flush sequence and a data-memory wait watchdog.
// PARAMETERS
//  RST_FLUSH_CYC  5    cycles all pipeline registers are flushed after reset release (>=1)
//  MAX_MEM_WAIT   255  consecutive MEM_WAIT cycles before watchdog trips (>=1)
//  CNT_W          32   width of performance counters (CTRL_PERF_CNT_EN only)
// PORTS
//  clk           in   1      pipeline clock, all state updates on rising edge
//  rst_n         in   1      synchronous reset, active-low
//  hz_stall      in   1      stall request from hazard detection (load-use / branch operand)
//  br_taken      in   1      ID-stage branch/jump resolved taken, redirect PC this cycle
//  imem_ready    in   1      instruction memory returns valid fetch this cycle
//  dmem_req      in   1      MEM-stage instruction is a load/store
//  dmem_ready    in   1      data memory completes access this cycle
//  pc_write      out  1      PC register load enable
//  if_id_write   out  1      IF/ID register load enable
//  if_id_flush   out  1      IF/ID loads NOP (dominates if_id_write)
//  id_ex_bubble  out  1      ID/EX loads zeroed control (NOP)
//  ex_write      out  1      ID/EX and EX/MEM load enable
//  mem_wb_bubble out  1      MEM/WB loads zeroed control
//  wdog_err      out  1      sticky watchdog error, cleared only by reset
//  stall_cnt, flush_cnt, memwait_cnt  out  CNT_W  perf counters (see CONFIGURATION)
// BEHAVIOUR
//  - Outputs are combinational from registered state plus current inputs.
//    Same-cycle response to every request, zero added latency.
//  - FSM states: RST_FLUSH, RUN, MEM_WAIT, HALT.
//  - Reset (rst_n==0 at clk edge):
//    - State -> RST_FLUSH, flush counter -> RST_FLUSH_CYC-1, wait counter -> 0, wdog_err -> 0, perf counters -> 0.
//    - While rst_n is low, outputs are held at: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_write=1, mem_wb_bubble=1.
//    - Reset mid-operation abandons any stall or wait immediately.
//  - RST_FLUSH:
//    - Same outputs as in reset. Counter decrements each cycle.
//    - Transition to RUN on the cycle the counter is 0, so the flush lasts exactly RST_FLUSH_CYC cycles.
//  - RUN (priority high->low, first match wins):
//    1) dmem_req & !dmem_ready: freeze pipe.
//       - Outputs: pc_write=0, if_id_write=0, ex_write=0, mem_wb_bubble=1; if_id_flush=0, id_ex_bubble=0.
//       - State -> MEM_WAIT, wait counter -> 1.
//    2) hz_stall: pc_write=0, if_id_write=0, id_ex_bubble=1, ex_write=1.
//       - br_taken is ignored while hz_stall=1.
//    3) br_taken: pc_write=1, if_id_flush=1, ex_write=1.
//       - Branch wins over imem wait: the wrong-path fetch is discarded either way.
//    4) !imem_ready: pc_write=0, if_id_flush=1, ex_write=1 (fetch bubble, back end drains).
//    5) Otherwise: all write enables 1, all flush/bubble outputs 0.
//  - MEM_WAIT:
//    - Outputs as RUN case 1 while !dmem_ready; wait counter increments, saturating at MAX_MEM_WAIT.
//    - On dmem_ready: evaluate as RUN cases 2-5 this cycle; state -> RUN, wait counter -> 0.
//    - If the counter reaches MAX_MEM_WAIT with dmem_ready still 0: state -> HALT, wdog_err -> 1 next cycle.
//  - HALT: pc_write=0, if_id_write=0, ex_write=0, mem_wb_bubble=1. Exit only via reset.
//  - Invariant: if_id_flush and if_id_write are never both 1, except in RUN case 3 (flush dominates).
// CONFIGURATION
//  - CTRL_PERF_CNT_EN defined:
//    - stall_cnt +1 per RUN case-2 cycle.
//    - flush_cnt +1 per RUN case-3 cycle.
//    - memwait_cnt +1 per case-1 or MEM_WAIT freeze cycle.
//    - All counters wrap modulo 2^CNT_W.
//  - CTRL_PERF_CNT_EN undefined: counters are not built and the three ports are tied to 0.
// STRUCTURE
//  - Package pipe_ctrl_pkg: FSM state encoding constants (RST_FLUSH=2'd0, RUN=2'd1, MEM_WAIT=2'd2, HALT=2'd3).
//  - Sub-module pipe_ctrl_wait_timer holds the saturating wait counter and watchdog compare.
//    - Interface: clear, inc, max-reached flag.
//    - Reused by the RST_FLUSH down-count via a mode input.
// TESTING
//  - Reset release, default params:
//    - RST_FLUSH outputs for exactly 5 cycles, then pc_write=1, if_id_write=1, all flush/bubble=0.
//  - In RUN, hz_stall=1 and br_taken=1 for 2 cycles:
//    - pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0 both cycles.
//    - Perf build: stall_cnt=2, flush_cnt=0.
//  - dmem_req=1, dmem_ready=0 for 3 cycles, then dmem_ready=1 with hz_stall=1:
//    - 3 freeze cycles with mem_wb_bubble=1 and ex_write=0.
//    - 4th cycle: stall outputs, state RUN.
//  - MAX_MEM_WAIT=4, dmem_ready held 0:
//    - wdog_err=1 after the 4th wait cycle, HALT outputs persist.
//    - Reset clears wdog_err=0 and state returns to RST_FLUSH.
//  - br_taken=1 with imem_ready=0: pc_write=1, if_id_flush=1, if_id_write=0.
//  - Assert rst_n=0 during MEM_WAIT: outputs switch to flush values in the same cycle; no further MEM_WAIT cycles.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared FSM encoding, per-stage enable bundle and the RUN-mode issue priority for the stall controller.
// Pure definitions: no state, no latency, no flow control of its own.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RST_FLUSH = 2'd0,
    RUN       = 2'd1,
    MEM_WAIT  = 2'd2,
    HALT      = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_write;
    logic mem_wb_bubble;
  } stage_en_t;

  localparam stage_en_t EN_FLUSH  = stage_en_t'(6'b001111);
  localparam stage_en_t EN_FREEZE = stage_en_t'(6'b000001);

  // RUN priority below the memory freeze: hazard stall, then redirect, then fetch miss.
  function automatic stage_en_t issue_en(input logic hz, input logic br, input logic imem_rdy);
    stage_en_t e;
    e = stage_en_t'(6'b110010);
    if (hz) begin
      e = stage_en_t'(6'b000110);
    end else if (br) begin
      // Redirect flushes IF/ID; flush dominates whatever write the fetch side offers.
      e = stage_en_t'({1'b1, imem_rdy, 4'b1010});
    end else if (!imem_rdy) begin
      e = stage_en_t'(6'b001010);
    end
    return e;
  endfunction

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_wait_timer.sv
// Shared counter: saturating up-count for the data-memory watchdog, down-count for the reset flush.
// One-cycle registered count; max_o is combinational from the current count and mode.
module pipe_ctrl_wait_timer #(
  parameter int W          = 8,
  parameter int MAX_WAIT   = 255,
  parameter int FLUSH_INIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_mode_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic max_o
);

  localparam logic [W-1:0] CNT_MAX  = W'(MAX_WAIT);
  localparam logic [W-1:0] PRE_MAX  = W'(MAX_WAIT - 1);
  localparam logic [W-1:0] CNT_INIT = W'(FLUSH_INIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (flush_mode_i) begin
        if (cnt_q != '0) cnt_d = cnt_q - W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= CNT_INIT;
    else        cnt_q <= cnt_d;
  end

  // Wait mode flags the cycle whose increment lands on MAX_WAIT; flush mode flags the last flush cycle.
  assign max_o = flush_mode_i ? (cnt_q == '0) : (cnt_q >= PRE_MAX);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipe: zero-latency enables, freezes on dmem wait, stalls upstream on hazards.
// Post-reset flush, dmem watchdog into HALT; perf counters only when CTRL_PERF_CNT_EN is defined.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int RST_FLUSH_CYC = 5,
  parameter int MAX_MEM_WAIT  = 255,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall,
  input  logic             br_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_write,
  output logic             mem_wb_bubble,
  output logic             wdog_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam int TMR_W = cnt_width(MAX_MEM_WAIT, RST_FLUSH_CYC);

  ctrl_state_e state_q, state_d;
  logic        wdog_q, wdog_d;
  logic        tmr_inc, tmr_clr, tmr_max;
  stage_en_t   en;

  pipe_ctrl_wait_timer #(
    .W         (TMR_W),
    .MAX_WAIT  (MAX_MEM_WAIT),
    .FLUSH_INIT(RST_FLUSH_CYC - 1)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_mode_i(state_q == RST_FLUSH),
    .clr_i       (tmr_clr),
    .inc_i       (tmr_inc),
    .max_o       (tmr_max)
  );

  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    tmr_inc = 1'b0;
    tmr_clr = 1'b0;
    en      = EN_FREEZE;
    case (state_q)
      RST_FLUSH: begin
        en      = EN_FLUSH;
        tmr_inc = 1'b1;
        if (tmr_max) state_d = RUN;
      end
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          en      = EN_FREEZE;
          tmr_inc = 1'b1;
          state_d = MEM_WAIT;
        end else begin
          en = issue_en(hz_stall, br_taken, imem_ready);
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          en      = EN_FREEZE;
          tmr_inc = 1'b1;
          if (tmr_max) begin
            state_d = HALT;
            wdog_d  = 1'b1;
          end
        end else begin
          en      = issue_en(hz_stall, br_taken, imem_ready);
          tmr_clr = 1'b1;
          state_d = RUN;
        end
      end
      HALT:    en = EN_FREEZE;
      default: en = EN_FLUSH;
    endcase
    // Reset overrides combinationally so an in-flight stall or wait is dropped the same cycle.
    if (!rst_n) en = EN_FLUSH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RST_FLUSH;
      wdog_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
    end
  end

  assign pc_write      = en.pc_write;
  assign if_id_write   = en.if_id_write;
  assign if_id_flush   = en.if_id_flush;
  assign id_ex_bubble  = en.id_ex_bubble;
  assign ex_write      = en.ex_write;
  assign mem_wb_bubble = en.mem_wb_bubble;
  assign wdog_err      = wdog_q;

`ifdef CTRL_PERF_CNT_EN
  logic             frz, issue_ok;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

  assign frz      = !dmem_ready && ((state_q == RUN && dmem_req) || state_q == MEM_WAIT);
  assign issue_ok = (state_q == RUN || state_q == MEM_WAIT) && !frz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      if (issue_ok && hz_stall)              stall_cnt_q   <= stall_cnt_q + CNT_W'(1);
      if (issue_ok && !hz_stall && br_taken) flush_cnt_q   <= flush_cnt_q + CNT_W'(1);
      if (frz)                               memwait_cnt_q <= memwait_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign memwait_cnt = memwait_cnt_q;
`else
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
  assign memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: vector table, directed corner sequences, then random traffic vs a rule model.
// Input vectors are packed as {rst_n, hz_stall, br_taken, imem_ready, dmem_req, dmem_ready}.
module tb_pipeline_stall_controller;

  localparam int RSTC = 5;
  localparam int MAXW = 4;
  localparam int CW   = 32;

  // Output order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_write, mem_wb_bubble}
  localparam logic [5:0] O_FLUSH  = 6'b001111;
  localparam logic [5:0] O_FREEZE = 6'b000001;
  localparam logic [5:0] O_STALL  = 6'b000110;
  localparam logic [5:0] O_IMISS  = 6'b001010;
  localparam logic [5:0] O_GO     = 6'b110010;
  localparam logic [5:0] O_BR0    = 6'b101010;
  localparam logic [5:0] O_BR1    = 6'b111010;

  logic clk = 1'b0;
  logic rst_n, hz_stall, br_taken, imem_ready, dmem_req, dmem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_write, mem_wb_bubble, wdog_err;
  logic [CW-1:0] stall_cnt, flush_cnt, memwait_cnt;

  always #5 clk = ~clk;

  pipeline_stall_controller #(
    .RST_FLUSH_CYC(RSTC),
    .MAX_MEM_WAIT (MAXW),
    .CNT_W        (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hz_stall     (hz_stall),
    .br_taken     (br_taken),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_write     (ex_write),
    .mem_wb_bubble(mem_wb_bubble),
    .wdog_err     (wdog_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .memwait_cnt  (memwait_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cycles of flush left, whether a memory wait is in progress and how long, halt/error flags.
  int            flush_left  = RSTC;
  int            wait_cycles = 0;
  bit            waiting     = 1'b0;
  bit            halted      = 1'b0;
  bit            m_wdog      = 1'b0;
  logic [CW-1:0] m_stall = '0, m_flush = '0, m_memw = '0;

  function automatic void chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endfunction

  function automatic logic [5:0] model_out(input logic [5:0] in);
    logic r, hz, br, im, dq, dr;
    {r, hz, br, im, dq, dr} = in;
    if (!r || flush_left > 0)      return O_FLUSH;
    if (halted)                    return O_FREEZE;
    if ((waiting || dq) && !dr)    return O_FREEZE;
    if (hz)                        return O_STALL;
    if (br)                        return im ? O_BR1 : O_BR0;
    if (!im)                       return O_IMISS;
    return O_GO;
  endfunction

  function automatic void model_step(input logic [5:0] in);
    logic r, hz, br, im, dq, dr;
    {r, hz, br, im, dq, dr} = in;
    if (!r) begin
      flush_left = RSTC; waiting = 1'b0; wait_cycles = 0;
      halted = 1'b0; m_wdog = 1'b0;
      m_stall = '0; m_flush = '0; m_memw = '0;
    end else if (flush_left > 0) begin
      flush_left--;
    end else if (halted) begin
      // only reset leaves a halt
    end else if ((waiting || dq) && !dr) begin
      wait_cycles++;
      m_memw = m_memw + 1;
      if (waiting && wait_cycles >= MAXW) begin
        halted = 1'b1;
        m_wdog = 1'b1;
      end
      waiting = 1'b1;
    end else begin
      if (hz)      m_stall = m_stall + 1;
      else if (br) m_flush = m_flush + 1;
      waiting = 1'b0;
      wait_cycles = 0;
    end
  endfunction

  function automatic logic [127:0] exp_cnt();
`ifdef CTRL_PERF_CNT_EN
    return 128'({m_stall, m_flush, m_memw});
`else
    return '0;
`endif
  endfunction

  task automatic cycle(input logic [5:0] in, input bit use_k, input logic [5:0] k, input string nm);
    logic [5:0] dut_o;
    {rst_n, hz_stall, br_taken, imem_ready, dmem_req, dmem_ready} = in;
    @(negedge clk);
    dut_o = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_write, mem_wb_bubble};
    chk({nm, " ctl"}, 128'({dut_o, wdog_err}), 128'({model_out(in), m_wdog}));
    if (use_k) chk({nm, " ref"}, 128'(dut_o), 128'(k));
    chk({nm, " cnt"}, 128'({stall_cnt, flush_cnt, memwait_cnt}), exp_cnt());
    @(posedge clk);
    model_step(in);
    #1;
  endtask

  typedef struct {
    logic [5:0] in;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [CW-1:0] s0, f0;
    logic [5:0]    rin;

    tbl[0] = '{in: 6'b100100, exp: O_GO};
    tbl[1] = '{in: 6'b100111, exp: O_GO};
    tbl[2] = '{in: 6'b110100, exp: O_STALL};
    tbl[3] = '{in: 6'b111000, exp: O_STALL};
    tbl[4] = '{in: 6'b101100, exp: O_BR1};
    tbl[5] = '{in: 6'b101000, exp: O_BR0};
    tbl[6] = '{in: 6'b100000, exp: O_IMISS};
    tbl[7] = '{in: 6'b110111, exp: O_STALL};
    tbl[8] = '{in: 6'b101011, exp: O_BR0};
    tbl[9] = '{in: 6'b100011, exp: O_IMISS};

    {rst_n, hz_stall, br_taken, imem_ready, dmem_req, dmem_ready} = 6'b000100;
    @(posedge clk);
    #1;

    // Reset hold, exact flush length, first RUN cycle.
    repeat (2) cycle(6'b000100, 1'b1, O_FLUSH, "rst hold");
    for (int i = 0; i < RSTC; i++) cycle(6'b100100, 1'b1, O_FLUSH, $sformatf("flush%0d", i));
    cycle(6'b100100, 1'b1, O_GO, "first run");

    for (int i = 0; i < 10; i++) cycle(tbl[i].in, 1'b1, tbl[i].exp, $sformatf("vec%0d", i));

    // Hazard stall beats a taken branch.
    s0 = stall_cnt; f0 = flush_cnt;
    repeat (2) cycle(6'b111100, 1'b1, O_STALL, "hz+br");
`ifdef CTRL_PERF_CNT_EN
    chk("stall_cnt delta", 128'(stall_cnt - s0), 128'(2));
    chk("flush_cnt delta", 128'(flush_cnt - f0), 128'(0));
`endif

    // Three freeze cycles, then completion with a hazard pending.
    repeat (3) cycle(6'b100110, 1'b1, O_FREEZE, "memwait");
    cycle(6'b110111, 1'b1, O_STALL, "mem done+hz");
    cycle(6'b100100, 1'b1, O_GO, "after mem");

    // Watchdog: four freeze cycles trip into HALT; only reset recovers.
    for (int i = 0; i < MAXW; i++) begin
      chk("wdog before trip", 128'(wdog_err), 128'(0));
      cycle(6'b100110, 1'b1, O_FREEZE, "wd wait");
    end
    chk("wdog set", 128'(wdog_err), 128'(1));
    repeat (3) cycle(6'b100111, 1'b1, O_FREEZE, "halt");
    chk("wdog sticky", 128'(wdog_err), 128'(1));
    cycle(6'b000100, 1'b1, O_FLUSH, "halt rst");
    chk("wdog clr", 128'(wdog_err), 128'(0));
    for (int i = 0; i < RSTC; i++) cycle(6'b100100, 1'b1, O_FLUSH, "flush after halt");
    cycle(6'b100100, 1'b1, O_GO, "run after halt");

    // Reset in the middle of a memory wait.
    repeat (2) cycle(6'b100110, 1'b1, O_FREEZE, "pre rst wait");
    cycle(6'b000110, 1'b1, O_FLUSH, "rst in wait");
    for (int i = 0; i < RSTC; i++) cycle(6'b100110, 1'b1, O_FLUSH, "flush after wait rst");
    cycle(6'b100110, 1'b1, O_FREEZE, "fresh wait");
    cycle(6'b100111, 1'b1, O_GO, "wait done");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rin[5] = ($urandom_range(99) >= 2);
      rin[4] = ($urandom_range(3) == 0);
      rin[3] = ($urandom_range(3) == 0);
      rin[2] = ($urandom_range(4) != 0);
      rin[1] = ($urandom_range(2) == 0);
      rin[0] = ($urandom_range(9) < 7);
      cycle(rin, 1'b0, 6'b0, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
